// File: rtl/adff_share_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter in front of the async-reset register.
// Holds the FSM state encoding, the index-width rule and the round-robin winner search.
package adff_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int unsigned MAX_NREQ = 32;
    localparam int unsigned MAX_IW   = $clog2(MAX_NREQ);
    localparam int unsigned DEF_NREQ = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned IDX_W = idx_width(DEF_NREQ);

    // First set bit of req scanning ptr, ptr+1, ... with wrap modulo nreq; 0 when req is empty.
    function automatic int unsigned rr_pick(input logic [MAX_NREQ-1:0] req,
                                            input int unsigned       ptr,
                                            input int unsigned       nreq);
        logic [MAX_IW-1:0] idx;
        int unsigned       win;
        logic              found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            idx = MAX_IW'((ptr + k) % nreq);
            if (k < nreq && !found && req[idx]) begin
                found = 1'b1;
                win   = int'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/adff_share_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: requests, data, clear and grant/Q status.
// master drives REQ/D/CLR; slave (the arbiter) drives the grant and register view.
interface adff_share_arbiter_if
    import adff_share_pkg::*;
#(
    parameter int unsigned WIDTH = 5,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned IW = idx_width(NREQ);

    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] D;
    logic                  CLR;
    logic [NREQ-1:0]       GNT;
    logic [WIDTH-1:0]      Q;
    logic [IW-1:0]         Q_OWNER;
    logic                  Q_VALID;
    logic                  BUSY;

    modport master (
        output REQ, D, CLR,
        input  GNT, Q, Q_OWNER, Q_VALID, BUSY
    );

    modport slave (
        input  REQ, D, CLR,
        output GNT, Q, Q_OWNER, Q_VALID, BUSY
    );

endinterface

// File: rtl/adff_reg.sv
// WIDTH-bit storage register with async active-high reset, sync clear (wins) and load enable.
// One-cycle load latency; holds its value whenever neither clear nor enable is asserted.
module adff_reg #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_arst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/adff_share_arbiter.sv
// Round-robin owner of one shared async-reset register: grant, load on the next edge, hold, rotate.
// Grant lasts 1+HOLD_CYCLES cycles unless the owner drops REQ; losing requesters simply wait.
module adff_share_arbiter
    import adff_share_pkg::*;
#(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic                 CLK,
    input logic                 ARST,
    adff_share_arbiter_if.slave bus
);

    localparam int unsigned IW = idx_width(NREQ);
    localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e           r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    r_win, w_win_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [IW-1:0]    w_pick;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic             r_valid, w_valid_nxt;
    logic             w_load;
    logic             w_clr;
    logic [WIDTH-1:0] w_d_sel;
    logic [WIDTH-1:0] w_q;

    assign w_pick  = IW'(rr_pick(MAX_NREQ'(bus.REQ), int'(r_ptr), NREQ));
    assign w_d_sel = bus.D[r_win*WIDTH +: WIDTH];
    assign w_clr   = bus.CLR;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_win_nxt   = r_win;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_valid_nxt = r_valid;
        w_load      = 1'b0;

        if (bus.CLR) begin
            // Abort leaves the pointer alone so the interrupted owner keeps its turn.
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (|bus.REQ) begin
                        w_win_nxt   = w_pick;
                        w_gnt_nxt   = NREQ'(1) << w_pick;
                        w_state_nxt = LOAD;
                    end
                end
                LOAD: begin
                    w_load      = 1'b1;
                    w_owner_nxt = r_win;
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                    w_state_nxt = HOLD;
                end
                HOLD: begin
                    if (r_cnt == '0 || !bus.REQ[r_win]) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_ptr_nxt   = (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ARST) begin
        if (ARST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_owner <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_win   <= w_win_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    adff_reg #(
        .WIDTH (WIDTH)
    ) u_q_reg (
        .i_clk  (CLK),
        .i_arst (ARST),
        .i_en   (w_load),
        .i_clr  (w_clr),
        .i_d    (w_d_sel),
        .o_q    (w_q)
    );

    assign bus.GNT     = r_gnt;
    assign bus.Q       = w_q;
    assign bus.Q_OWNER = r_owner;
    assign bus.Q_VALID = r_valid;
    assign bus.BUSY    = (r_state != IDLE);

    always_ff @(posedge CLK) begin
        if (!ARST) begin
            assert ($onehot0(r_gnt));
            assert (int'(r_win) < NREQ);
        end
    end

endmodule

// File: tb/tb_adff_share_arbiter.sv
// Directed bench for adff_share_arbiter: WIDTH=5, NREQ=4, HOLD_CYCLES=2, hand-computed expectations.
module tb_adff_share_arbiter;

    logic       clk;
    logic       arst;
    logic [4:0] d [4];
    int         checks;
    int         passed;

    adff_share_arbiter_if #(.WIDTH(5), .NREQ(4)) bus ();

    assign bus.D = {d[3], d[2], d[1], d[0]};

    adff_share_arbiter #(
        .WIDTH       (5),
        .NREQ        (4),
        .HOLD_CYCLES (2)
    ) dut (
        .CLK  (clk),
        .ARST (arst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks  = 0;
        passed  = 0;
        arst    = 1'b1;
        bus.REQ = '0;
        bus.CLR = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // reset state
        #3;
        check("rst_gnt",   32'(bus.GNT),     32'h0);
        check("rst_q",     32'(bus.Q),       32'h0);
        check("rst_valid", 32'(bus.Q_VALID), 32'h0);
        check("rst_busy",  32'(bus.BUSY),    32'h0);
        check("rst_owner", 32'(bus.Q_OWNER), 32'h0);
        @(negedge clk);
        arst = 1'b0;

        // single request from requester 2
        d[2]    = 5'h0B;
        bus.REQ = 4'b0100;
        tick;
        check("t1_gnt_rise",  32'(bus.GNT),     32'h4);
        check("t1_busy",      32'(bus.BUSY),    32'h1);
        check("t1_q_pre",     32'(bus.Q),       32'h0);
        check("t1_valid_pre", 32'(bus.Q_VALID), 32'h0);
        tick;
        check("t1_q_load",    32'(bus.Q),       32'h0B);
        check("t1_owner",     32'(bus.Q_OWNER), 32'h2);
        check("t1_valid",     32'(bus.Q_VALID), 32'h1);
        check("t1_gnt_2",     32'(bus.GNT),     32'h4);
        tick;
        check("t1_gnt_3",     32'(bus.GNT),     32'h4);
        tick;
        check("t1_gnt_fall",  32'(bus.GNT),     32'h0);
        check("t1_idle_busy", 32'(bus.BUSY),    32'h0);
        bus.REQ = '0;
        tick;
        check("t1_idle_gnt",  32'(bus.GNT),     32'h0);
        check("t1_q_hold",    32'(bus.Q),       32'h0B);

        // async reset pulse between edges clears Q and ptr
        #2 arst = 1'b1;
        #1 check("t1_arst_q", 32'(bus.Q), 32'h0);
        #1 arst = 1'b0;

        // rotation with all requesters active
        for (int i = 0; i < 4; i++) d[i] = 5'(i + 1);
        bus.REQ = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick;
            check("t2_gnt",      32'(bus.GNT),     32'(1) << (g % 4));
            tick;
            check("t2_q",        32'(bus.Q),       32'((g % 4) + 1));
            check("t2_owner",    32'(bus.Q_OWNER), 32'(g % 4));
            tick;
            check("t2_gnt_hold", 32'(bus.GNT),     32'(1) << (g % 4));
            tick;
            check("t2_gnt_rel",  32'(bus.GNT),     32'h0);
        end
        bus.REQ = '0;

        // early release: ptr is now 1, lone requester 0 wins
        d[0]    = 5'h15;
        bus.REQ = 4'b0001;
        tick;
        check("t3_gnt",      32'(bus.GNT),  32'h1);
        tick;
        check("t3_q",        32'(bus.Q),    32'h15);
        bus.REQ = '0;
        tick;
        check("t3_gnt_fall", 32'(bus.GNT),  32'h0);
        check("t3_busy",     32'(bus.BUSY), 32'h0);
        check("t3_q_keep",   32'(bus.Q),    32'h15);
        d[1]    = 5'h0A;
        bus.REQ = 4'b0011;
        tick;
        check("t3_ptr1",     32'(bus.GNT),  32'h2);
        bus.REQ = '0;
        tick;
        check("t3_commit_q", 32'(bus.Q),       32'h0A);
        check("t3_commit_o", 32'(bus.Q_OWNER), 32'h1);
        tick;
        check("t3_rel",      32'(bus.GNT),     32'h0);

        // clear during hold; ptr=2 so requester 3 wins twice
        d[3]    = 5'h1C;
        bus.REQ = 4'b1001;
        tick;
        check("t4_gnt",       32'(bus.GNT), 32'h8);
        tick;
        check("t4_q",         32'(bus.Q),   32'h1C);
        bus.CLR = 1'b1;
        tick;
        bus.CLR = 1'b0;
        check("t4_clr_q",     32'(bus.Q),       32'h0);
        check("t4_clr_valid", 32'(bus.Q_VALID), 32'h0);
        check("t4_clr_gnt",   32'(bus.GNT),     32'h0);
        check("t4_clr_busy",  32'(bus.BUSY),    32'h0);
        check("t4_clr_owner", 32'(bus.Q_OWNER), 32'h3);
        tick;
        check("t4_regrant",   32'(bus.GNT), 32'h8);
        tick;
        check("t4_reload",    32'(bus.Q),   32'h1C);
        bus.REQ = '0;
        tick;
        check("t4_rel",       32'(bus.GNT), 32'h0);

        // move ptr to 2, then async reset during LOAD
        d[1]    = 5'h07;
        bus.REQ = 4'b0010;
        tick;
        check("t5_pre_gnt", 32'(bus.GNT), 32'h2);
        bus.REQ = '0;
        tick;
        tick;
        check("t5_pre_rel", 32'(bus.GNT), 32'h0);
        d[2]    = 5'h13;
        bus.REQ = 4'b0100;
        tick;
        check("t5_load_gnt", 32'(bus.GNT), 32'h4);
        #2 arst = 1'b1;
        #1;
        check("t5_arst_q",     32'(bus.Q),       32'h0);
        check("t5_arst_gnt",   32'(bus.GNT),     32'h0);
        check("t5_arst_valid", 32'(bus.Q_VALID), 32'h0);
        check("t5_arst_busy",  32'(bus.BUSY),    32'h0);
        check("t5_arst_owner", 32'(bus.Q_OWNER), 32'h0);
        @(negedge clk);
        arst    = 1'b0;
        bus.REQ = 4'b1010;
        tick;
        check("t5_ptr0_gnt", 32'(bus.GNT), 32'h2);

        // data isolation: owner's D churns during HOLD
        tick;
        check("t6_q_load", 32'(bus.Q), 32'h07);
        for (int r = 0; r < 2; r++) begin
            repeat (9) begin
                #1 d[1] = d[1] + 5'd1;
            end
            #1;
            check("t6_q_stable", 32'(bus.Q), 32'h07);
        end
        check("t6_rel", 32'(bus.GNT), 32'h0);
        bus.REQ = '0;
        tick;
        check("t6_idle", 32'(bus.BUSY), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adff_share_arbiter.md
Name: adff_share_arbiter

Overview:
Round-robin arbiter that shares one WIDTH-bit asynchronously reset storage register among NREQ requesters. Each requester raises REQ with its data word. The arbiter grants one requester at a time, loads that requester's word into the shared register, and holds ownership for a bounded number of cycles so the owner can observe Q. Ownership then rotates. The block sits in front of the async-reset flip-flop datapath and is its only writer.

Parameters:
- WIDTH, 5: data width of the shared register.
- NREQ, 4: number of requesters; at least 2.
- HOLD_CYCLES, 2: cycles of ownership after the load cycle; at least 1.

Ports:
- CLK  input  1  rising-edge clock.
- ARST  input  1  asynchronous reset, active-high.
- REQ  input  NREQ  per-requester request level.
- D  input  NREQ*WIDTH  requester data, flattened; requester i occupies bits [i*WIDTH +: WIDTH].
- CLR  input  1  synchronous clear and abort.
- GNT  output  NREQ  one-hot grant, registered.
- Q  output  WIDTH  shared register contents.
- Q_OWNER  output  max(1,$clog2(NREQ))  index of the last requester that loaded Q.
- Q_VALID  output  1  Q holds a loaded word since the last reset or clear.
- BUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: when ARST is high, all outputs (GNT, Q, Q_OWNER, Q_VALID, BUSY) are 0 immediately, without waiting for CLK. Internal state also resets: state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- States: IDLE, LOAD, HOLD. All transitions occur on the rising edge of CLK.
- IDLE:
  - If REQ is nonzero, the winner is the first set bit scanning ptr, ptr+1, … with wrap modulo NREQ.
  - Next edge: GNT=onehot(winner), state=LOAD, BUSY=1.
  - If REQ is zero, stay in IDLE with GNT=0.
- LOAD:
  - Next edge: Q=D[winner], Q_OWNER=winner, Q_VALID=1, cnt=HOLD_CYCLES-1, state=HOLD.
  - The load happens even if REQ[winner] dropped during LOAD; a grant is committed once issued.
- HOLD:
  - If cnt==0 or REQ[winner]==0: next edge state=IDLE, GNT=0, ptr=(winner+1) mod NREQ.
  - Otherwise cnt decrements.
- Timing with REQ first sampled high at edge k:
  - GNT is high from edge k through edge k+1+HOLD_CYCLES, i.e. 1+HOLD_CYCLES cycles when uninterrupted.
  - Q updates at edge k+1.
  - At least one IDLE cycle separates consecutive grants.
- Q changes only on LOAD, CLR, or ARST. Q holds its value in every other cycle.
- D and REQ changes outside LOAD do not affect Q.
- CLR, sampled high in any state: next edge Q=0, Q_VALID=0, GNT=0, state=IDLE, and ptr is unchanged.
  - CLR has priority over a simultaneous LOAD.
  - Q_OWNER is not cleared by CLR.
- Simultaneous requests: resolved strictly by ptr, which rotates only on release. A requester holding REQ continuously is served within NREQ grants.
- ARST asserted mid-grant: everything resets immediately. After ARST release, arbitration restarts from ptr=0.
- Out-of-range hardening: the winner index is always less than NREQ, and GNT is never multi-hot (assertion in RTL).

Decomposition:
- Package adff_share_pkg holds:
  - the state enum (IDLE, LOAD, HOLD);
  - the localparam for index width;
  - function rr_pick(req, ptr), which returns the winner index.
- One sub-module, adff_reg: a WIDTH-bit register with ARST (async active-high), CLK, load enable, synchronous clear, D, and Q.
  - The arbiter instantiates exactly one adff_reg for Q.

Test Plan:
All scenarios use WIDTH=5, NREQ=4, HOLD_CYCLES=2.

1. Single request: ARST pulse, then REQ=4'b0100 held, D[2]=5'h0B → GNT=4'b0100 for 3 cycles; Q=5'h0B one edge after GNT rises; Q_OWNER=2; Q_VALID=1; then GNT=0 and one IDLE cycle.
2. Rotation: REQ=4'b1111 held, D[i]=i+1 → grant order 0,1,2,3,0; Q sequence 1,2,3,4,1; each grant lasts 3 cycles.
3. Early release: REQ=4'b0001, dropped one cycle after Q loads → GNT falls after 2 cycles instead of 3; ptr=1; Q retains the loaded value.
4. CLR during HOLD: grant active to requester 3, CLR pulse → next edge Q=0, Q_VALID=0, GNT=0, BUSY=0, Q_OWNER=3. With REQ=4'b1001 held, the next grant goes to requester 3 again because ptr is unchanged by CLR.
5. Async reset mid-grant: ARST raised between clock edges during LOAD → Q, GNT, Q_VALID, and BUSY are 0 before the next CLK edge. After release with REQ=4'b1010, the first grant goes to requester 1 (ptr=0).
6. Data isolation: D for the granted requester incremented every 1 ns during HOLD (D[owner] bus, sole owner) → Q stays equal to the value sampled at the LOAD edge.
